// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: access sizes and FSM states.
package mem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Right-justified raw lanes to final read data.
    function automatic logic [31:0] extend(
        input logic [31:0] raw,
        input logic [1:0]  size,
        input logic        sx
    );
        logic [31:0] r;
        unique case (1'b1)
            (size == SZ_BYTE): r = {{24{sx & raw[7]}}, raw[7:0]};
            (size == SZ_HALF): r = {{16{sx & raw[15]}}, raw[15:0]};
            default:           r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_ctrl.sv
// Byte-enable, forced alignment and misalign detection for one access.
module mem_lane_ctrl
    import mem_responder_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic [1:0]    size_i,
    input  logic [AW-1:0] addr_i,
    output logic [3:0]    be_o,
    output logic [AW-1:0] addr_o,
    output logic          misalign_o
);

    // be_o[k] enables byte k of the right-justified data.
    always_comb begin
        be_o       = 4'b1111;
        addr_o     = {addr_i[AW-1:2], 2'b00};
        misalign_o = |addr_i[1:0];
        unique case (1'b1)
            (size_i == SZ_BYTE): begin
                be_o       = 4'b0001;
                addr_o     = addr_i;
                misalign_o = 1'b0;
            end
            (size_i == SZ_HALF): begin
                be_o       = 4'b0011;
                addr_o     = {addr_i[AW-1:1], 1'b0};
                misalign_o = addr_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Big-endian byte-addressed memory model behind a MOV/MOC 4-phase handshake.
// Define ALIGN_CHECK_EN to flag (and suppress) misaligned accesses via ERR.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        ERR
);

    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            rw_q;
    logic [1:0]      size_q;
    logic            sx_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     dout_q;
    logic            moc_q;
    logic            err_q;

    logic [7:0]      mem_q [DEPTH];

    logic [3:0]      be;
    logic [AW-1:0]   base;
    logic            mis;
    logic            bad;
    logic            commit;
    logic            we;
    logic [AW-1:0]   lane_addr [4];
    logic [31:0]     raw;
    logic [31:0]     rdata;
    logic            unused_addr;

    assign unused_addr = ^Address[31:AW];

    mem_lane_ctrl #(.AW(AW)) u_lane (
        .size_i     (size_q),
        .addr_i     (addr_q),
        .be_o       (be),
        .addr_o     (base),
        .misalign_o (mis)
    );

`ifdef ALIGN_CHECK_EN
    assign bad = mis;
`else
    logic unused_mis;
    assign unused_mis = mis;
    assign bad = 1'b0;
`endif

    // Lane 0 is the LSB, which sits at the highest address of the access.
    always_comb begin
        logic [1:0] top;
        top = be[3] ? 2'd3 : (be[1] ? 2'd1 : 2'd0);
        raw = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = base + AW'(top - 2'(k));
            if (be[k]) begin
                raw[8*k +: 8] = mem_q[lane_addr[k]];
            end
        end
    end

    assign rdata  = extend(raw, size_q, sx_q);
    assign commit = (state_q == ST_BUSY) && (cnt_q == 4'd0) && MOV;
    assign we     = commit && !rw_q && !bad;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem_q[lane_addr[k]] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sx_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (MOV) begin
                        rw_q    <= RW;
                        size_q  <= Size;
                        sx_q    <= SignExt;
                        addr_q  <= Address[AW-1:0];
                        wdata_q <= DataIn;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!MOV) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (rw_q) begin
                            dout_q <= bad ? 32'h0 : rdata;
                        end
                        moc_q   <= 1'b1;
                        err_q   <= bad;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!MOV) begin
                        moc_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 and LATENCY=4 instances.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mov  [2];
    logic        rw   [2];
    logic [1:0]  size [2];
    logic        sx   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        moc  [2];
    logic        err  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(9), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(rst_n), .MOV(mov[0]), .RW(rw[0]),
        .Size(size[0]), .SignExt(sx[0]), .Address(addr[0]),
        .DataIn(din[0]), .DataOut(dout[0]), .MOC(moc[0]), .ERR(err[0])
    );

    mem_responder #(.ADDR_WIDTH(9), .LATENCY(4)) u_dut1 (
        .clk(clk), .reset(rst_n), .MOV(mov[1]), .RW(rw[1]),
        .Size(size[1]), .SignExt(sx[1]), .Address(addr[1]),
        .DataIn(din[1]), .DataOut(dout[1]), .MOC(moc[1]), .ERR(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full handshake; lat counts posedges including the sampling edge.
    task automatic xfer(input int k, input logic r, input logic [1:0] sz,
                        input logic s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] q,
                        output logic e, output int lat);
        @(negedge clk);
        mov[k] = 1'b1; rw[k] = r; size[k] = sz;
        sx[k] = s; addr[k] = a; din[k] = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!moc[k] && lat < 20);
        q = dout[k];
        e = err[k];
        @(negedge clk);
        mov[k] = 1'b0;
        rw[k] = 1'b0; din[k] = 32'h5A5A5A5A;
        @(posedge clk); #1;
        check("moc_fall", {31'b0, moc[k]}, 32'h0);
    endtask

    logic [31:0] q;
    logic        e;
    int          lat;
    bit          seen;
    logic [31:0] exp_mis_word;
    logic [31:0] exp_mis_half;
    logic        exp_err;

    initial begin
        for (int k = 0; k < 2; k++) begin
            mov[k] = 1'b0; rw[k] = 1'b0; size[k] = 2'b00;
            sx[k] = 1'b0; addr[k] = '0; din[k] = '0;
        end
`ifdef ALIGN_CHECK_EN
        exp_mis_word = 32'h01020304;
        exp_mis_half = 32'h00000000;
        exp_err      = 1'b1;
`else
        exp_mis_word = 32'h55667788;
        exp_mis_half = 32'h0000DEAD;
        exp_err      = 1'b0;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_out", {moc[0], err[0], dout[0][29:0]}, 32'h0);
        end

        xfer(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, q, e, lat);
        check("wr_latency", lat - 1, 32'd2);
        check("wr_err", {31'b0, e}, 32'h0);
        check("wr_dout_hold", q, 32'h0);
        xfer(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, q, e, lat);
        check("rd_word", q, 32'hDEADBEEF);
        check("rd_latency", lat - 1, 32'd2);
        xfer(0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0, q, e, lat);
        check("rd_byte_u", q, 32'h000000DE);

        xfer(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h80FF1234, q, e, lat);
        xfer(0, 1'b1, 2'b00, 1'b1, 32'h21, 32'h0, q, e, lat);
        check("rd_byte_s", q, 32'hFFFFFFFF);
        xfer(0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h0, q, e, lat);
        check("rd_half_u", q, 32'h000080FF);
        xfer(0, 1'b1, 2'b01, 1'b1, 32'h22, 32'h0, q, e, lat);
        check("rd_half_s", q, 32'h00001234);
        xfer(0, 1'b0, 2'b00, 1'b0, 32'h23, 32'h000000AA, q, e, lat);
        xfer(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, q, e, lat);
        check("byte_merge", q, 32'h80FF12AA);
        xfer(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, q, e, lat);
        xfer(0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h0, q, e, lat);
        check("half_merge", q, 32'h80FFBEEF);

        xfer(0, 1'b0, 2'b10, 1'b0, 32'h1FC, 32'hCAFEF00D, q, e, lat);
        xfer(0, 1'b1, 2'b00, 1'b0, 32'h3FF, 32'h0, q, e, lat);
        check("wrap_byte", q, 32'h0000000D);
        xfer(0, 1'b1, 2'b00, 1'b1, 32'hFFFF_FFFD, 32'h0, q, e, lat);
        check("wrap_byte_s", q, 32'hFFFFFFFE);

        xfer(0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0, q, e, lat);
        check("mis_half_rd", q, exp_mis_half);
        check("mis_half_err", {31'b0, e}, {31'b0, exp_err});
        xfer(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h01020304, q, e, lat);
        xfer(0, 1'b0, 2'b10, 1'b0, 32'h41, 32'h55667788, q, e, lat);
        check("mis_wr_err", {31'b0, e}, {31'b0, exp_err});
        xfer(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, q, e, lat);
        check("mis_wr_word", q, exp_mis_word);

        xfer(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h12345678, q, e, lat);
        check("lat4", lat - 1, 32'd4);
        xfer(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, q, e, lat);
        check("lat4_rd", q, 32'h12345678);

        @(negedge clk);
        mov[1] = 1'b1; rw[1] = 1'b0; size[1] = 2'b10;
        addr[1] = 32'h30; din[1] = 32'h11111111;
        @(negedge clk);
        mov[1] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= moc[1];
        end
        check("abort_moc", {31'b0, seen}, 32'h0);
        check("abort_dout", dout[1], 32'h12345678);
        xfer(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, q, e, lat);
        check("abort_word", q, 32'h12345678);

        @(negedge clk);
        mov[1] = 1'b1; rw[1] = 1'b0; size[1] = 2'b10;
        addr[1] = 32'h30; din[1] = 32'h11111111;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_moc", {31'b0, moc[1]}, 32'h0);
        check("rst_dout", dout[1], 32'h0);
        @(negedge clk);
        mov[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen |= moc[1];
        end
        check("rst_abort_moc", {31'b0, seen}, 32'h0);
        xfer(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, q, e, lat);
        check("rst_abort_word", q, 32'h12345678);
        xfer(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, q, e, lat);
        check("mem_kept_rst", q, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
